// File: rtl/mem_sram_responder.sv
// rtl/mem_sram_responder.sv - 32-bit word command responder over a 16-bit async SRAM
module mem_sram_responder #(
    parameter int ADDR_W      = 17,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        mem_cmd,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wr_data,
    output logic [31:0]       mem_rd_data,
    output logic              mem_rd_valid,
    output logic              mem_wr_done,
    output logic              mem_ready,
    output logic              mem_cmd_drop,
    output logic [ADDR_W:0]   sram_addr,
    output logic [15:0]       sram_dq_o,
    input  logic [15:0]       sram_dq_i,
    output logic              sram_dq_oe,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic              sram_ub_n,
    output logic              sram_lb_n
);
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] RD_HI     = 3'd1;
    localparam logic [2:0] RD_LO     = 3'd2;
    localparam logic [2:0] WR_HI     = 3'd3;
    localparam logic [2:0] WR_HI_REC = 3'd4;
    localparam logic [2:0] WR_LO     = 3'd5;
    localparam logic [2:0] WR_LO_REC = 3'd6;

    localparam logic [1:0] CMD_RD = 2'b01;
    localparam logic [1:0] CMD_WR = 2'b10;

    // Width of at least one bit even when WAIT_CYCLES is zero.
    localparam int CNT_W = $clog2(WAIT_CYCLES + 2);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);

    logic [2:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       wr_lo_q;
    logic [15:0]       hi_reg;
    logic              last;

    assign last = (cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            addr_q       <= '0;
            wr_lo_q      <= '0;
            hi_reg       <= '0;
            mem_rd_data  <= '0;
            mem_rd_valid <= 1'b0;
            mem_wr_done  <= 1'b0;
            mem_ready    <= 1'b1;
            mem_cmd_drop <= 1'b0;
            sram_addr    <= '0;
            sram_dq_o    <= '0;
            sram_dq_oe   <= 1'b0;
            sram_ce_n    <= 1'b1;
            sram_oe_n    <= 1'b1;
            sram_we_n    <= 1'b1;
            sram_ub_n    <= 1'b1;
            sram_lb_n    <= 1'b1;
        end else begin
            mem_rd_valid <= 1'b0;
            mem_wr_done  <= 1'b0;
            if (state != IDLE && (mem_cmd == CMD_RD || mem_cmd == CMD_WR))
                mem_cmd_drop <= 1'b1;

            case (state)
                IDLE: begin
                    if (mem_cmd == CMD_RD) begin
                        addr_q    <= mem_addr;
                        sram_addr <= {mem_addr, 1'b0};
                        sram_ce_n <= 1'b0;
                        sram_oe_n <= 1'b0;
                        sram_ub_n <= 1'b0;
                        sram_lb_n <= 1'b0;
                        mem_ready <= 1'b0;
                        cnt       <= CNT_LOAD;
                        state     <= RD_HI;
                    end else if (mem_cmd == CMD_WR) begin
                        addr_q     <= mem_addr;
                        wr_lo_q    <= mem_wr_data[15:0];
                        sram_addr  <= {mem_addr, 1'b0};
                        sram_dq_o  <= mem_wr_data[31:16];
                        sram_dq_oe <= 1'b1;
                        sram_ce_n  <= 1'b0;
                        sram_we_n  <= 1'b0;
                        sram_ub_n  <= 1'b0;
                        sram_lb_n  <= 1'b0;
                        mem_ready  <= 1'b0;
                        cnt        <= CNT_LOAD;
                        state      <= WR_HI;
                    end
                end
                RD_HI: begin
                    if (last) begin
                        hi_reg    <= sram_dq_i;
                        sram_addr <= {addr_q, 1'b1};
                        cnt       <= CNT_LOAD;
                        state     <= RD_LO;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RD_LO: begin
                    if (last) begin
                        mem_rd_data  <= {hi_reg, sram_dq_i};
                        mem_rd_valid <= 1'b1;
                        sram_ce_n    <= 1'b1;
                        sram_oe_n    <= 1'b1;
                        sram_ub_n    <= 1'b1;
                        sram_lb_n    <= 1'b1;
                        mem_ready    <= 1'b1;
                        state        <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                WR_HI: begin
                    if (last) begin
                        sram_we_n <= 1'b1;
                        state     <= WR_HI_REC;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                WR_HI_REC: begin
                    // Address and data change only while we_n is high.
                    sram_addr <= {addr_q, 1'b1};
                    sram_dq_o <= wr_lo_q;
                    sram_we_n <= 1'b0;
                    cnt       <= CNT_LOAD;
                    state     <= WR_LO;
                end
                WR_LO: begin
                    if (last) begin
                        sram_we_n <= 1'b1;
                        state     <= WR_LO_REC;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                WR_LO_REC: begin
                    sram_ce_n   <= 1'b1;
                    sram_dq_oe  <= 1'b0;
                    sram_ub_n   <= 1'b1;
                    sram_lb_n   <= 1'b1;
                    mem_wr_done <= 1'b1;
                    mem_ready   <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_sram_responder.sv
// tb/tb_mem_sram_responder.sv - scoreboard bench for mem_sram_responder with a behavioural SRAM
module tb_mem_sram_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  mem_cmd = 2'b00;
    logic [16:0] mem_addr = '0;
    logic [31:0] mem_wr_data = '0;
    logic [31:0] mem_rd_data;
    logic        mem_rd_valid, mem_wr_done, mem_ready, mem_cmd_drop;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_o, sram_dq_i;
    logic        sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

    mem_sram_responder #(.ADDR_W(17), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .mem_cmd(mem_cmd), .mem_addr(mem_addr),
        .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data),
        .mem_rd_valid(mem_rd_valid), .mem_wr_done(mem_wr_done),
        .mem_ready(mem_ready), .mem_cmd_drop(mem_cmd_drop),
        .sram_addr(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_i(sram_dq_i),
        .sram_dq_oe(sram_dq_oe), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n), .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
    );

    always #5 clk = ~clk;

    logic [15:0] sram [0:(1<<18)-1];
    assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? sram[sram_addr] : 16'h0000;
    always @(posedge clk)
        if (!sram_ce_n && !sram_we_n) sram[sram_addr] <= sram_dq_o;

    typedef struct {
        bit          is_rd;
        logic [31:0] data;
        int          due;
    } exp_t;
    exp_t exp_q[$];

    int cyc = 0;
    int passed = 0;
    int total = 0;
    int pin_viol = 0;
    int we_low = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Response monitor and pin-rule watcher, both sampled on the falling edge.
    always @(negedge clk) begin
        if (!sram_we_n) we_low++;
        if ((!sram_we_n && !sram_oe_n) || (sram_dq_oe && !sram_oe_n)) pin_viol++;
        if (!rst && (mem_rd_valid || mem_wr_done)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", {30'd0, mem_rd_valid, mem_wr_done}, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("pulse_kind", {30'd0, mem_rd_valid, mem_wr_done}, e.is_rd ? 32'd2 : 32'd1);
                if (e.is_rd) chk("rd_data", mem_rd_data, e.data);
                chk("latency_cycle", cyc, e.due);
            end
        end
    end

    task automatic issue(input logic [1:0] c, input logic [16:0] a, input logic [31:0] d,
                         input bit push, input logic [31:0] exp_data, output int acc);
        exp_t e;
        int n;
        n = 0;
        @(negedge clk);
        while (!mem_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("ready_timeout", {31'd0, mem_ready}, 32'd1);
        mem_cmd = c; mem_addr = a; mem_wr_data = d;
        @(posedge clk);
        #1;
        acc = cyc;
        mem_cmd = 2'b00;
        if (push) begin
            e.is_rd = (c == 2'b01);
            e.data  = exp_data;
            e.due   = acc + ((c == 2'b01) ? 6 : 8);
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !mem_ready) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("idle_timeout", exp_q.size(), 32'd0);
    endtask

    int acc_w, acc_r, acc_x;

    initial begin
        sram[18'h00020] = 16'h1234;
        sram[18'h00021] = 16'hABCD;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, mem_ready}, 32'd1);
        chk("rst_ctrl_pins", {27'd0, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}, 32'h1F);
        chk("rst_oe_valid_done_drop", {28'd0, sram_dq_oe, mem_rd_valid, mem_wr_done, mem_cmd_drop}, 32'd0);
        chk("rst_rd_data", mem_rd_data, 32'd0);
        chk("rst_sram_addr", {14'd0, sram_addr}, 32'd0);
        rst = 1'b0;

        issue(2'b01, 17'h00010, 32'd0, 1'b1, 32'h1234ABCD, acc_r);
        chk("rd_addr_hi", {14'd0, sram_addr}, 32'h20);
        chk("rd_ce_oe_lowbytes", {28'd0, sram_ce_n, sram_oe_n, sram_ub_n, sram_lb_n}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("rd_addr_lo", {14'd0, sram_addr}, 32'h21);
        wait_idle();

        we_low = 0;
        issue(2'b10, 17'h1FFFF, 32'hDEADBEEF, 1'b1, 32'd0, acc_w);
        issue(2'b01, 17'h1FFFF, 32'd0, 1'b1, 32'hDEADBEEF, acc_r);
        chk("back_to_back_accept", acc_r, acc_w + 9);
        wait_idle();
        chk("we_low_cycles", we_low, 32'd6);
        chk("mem_hi_written", {16'd0, sram[18'h3FFFE]}, 32'hDEAD);
        chk("mem_lo_written", {16'd0, sram[18'h3FFFF]}, 32'hBEEF);

        issue(2'b01, 17'h00010, 32'd0, 1'b1, 32'h1234ABCD, acc_r);
        @(posedge clk);
        @(negedge clk);
        mem_cmd = 2'b10; mem_addr = 17'h00010; mem_wr_data = 32'h55556666;
        @(posedge clk);
        #1;
        mem_cmd = 2'b00;
        chk("drop_set", {31'd0, mem_cmd_drop}, 32'd1);
        wait_idle();
        chk("drop_mem_hi_kept", {16'd0, sram[18'h00020]}, 32'h1234);
        chk("drop_mem_lo_kept", {16'd0, sram[18'h00021]}, 32'hABCD);
        repeat (3) @(negedge clk);
        chk("drop_sticky", {31'd0, mem_cmd_drop}, 32'd1);

        issue(2'b10, 17'h00005, 32'h11112222, 1'b0, 32'd0, acc_x);
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("in_wr_lo_we_low", {31'd0, sram_we_n}, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_ctrl_pins", {27'd0, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}, 32'h1F);
        chk("abort_oe_ready_drop", {29'd0, sram_dq_oe, mem_ready, mem_cmd_drop}, 32'b010);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 3; i++) begin
            mem_cmd = 2'b11;
            @(negedge clk);
            chk("rsvd_idle", {28'd0, sram_ce_n, mem_ready, mem_cmd_drop, sram_dq_oe}, 32'b1100);
        end
        mem_cmd = 2'b00;
        repeat (3) @(negedge clk);

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        chk("pin_rules", pin_viol, 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
